// File: rtl/bus_arb_pkg.sv
// Shared constants and encodings for the cache-refill bus arbiter.
// Holds default line/beat widths, the arbiter FSM states and the owner IDs.
package bus_arb_pkg;

    localparam int DEF_LINE_W = 1024;
    localparam int DEF_BUS_W  = 64;
    localparam int DEF_BEATS  = DEF_LINE_W / DEF_BUS_W;

    // Line-aligned base: a 1024-bit line spans 128 bytes.
    localparam logic [63:0] LINE_MASK = ~64'h7F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_DONE
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/bus_arb.sv
// Arbitrates I-cache refills and D-cache refills/writebacks onto one memory bus.
// Ports: clk/clr_n; i_rd,i_addr -> i_data,i_dv; d_rd,d_wr,d_addr,d_wdata -> d_rdata,d_dv;
// memory side m_rd,m_wr,m_addr,m_wdata out and m_rdata,m_ack in (one beat per ack).
module bus_arb
    import bus_arb_pkg::*;
#(
    parameter int LINE_W = DEF_LINE_W,
    parameter int BUS_W  = DEF_BUS_W
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              i_rd,
    input  logic [63:0]       i_addr,
    output logic [LINE_W-1:0] i_data,
    output logic              i_dv,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [63:0]       d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_dv,
    output logic              m_rd,
    output logic              m_wr,
    output logic [63:0]       m_addr,
    output logic [BUS_W-1:0]  m_wdata,
    input  logic [BUS_W-1:0]  m_rdata,
    input  logic              m_ack
);

    localparam int BEATS  = LINE_W / BUS_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST = BEAT_W'(BEATS - 1);

    state_t            state;
    state_t            state_nx;
    owner_t            owner;
    owner_t            lg;
    logic [BEAT_W-1:0] beat;
    logic [63:0]       base;
    logic [63:0]       beat_addr;
    logic [LINE_W-1:0] line_buf;
    logic              d_req;
    logic              grant;
    logic              grant_d;
    logic              busy;
    logic              last_ack;

    always_comb begin
        d_req     = d_rd | d_wr;
        grant     = (state == ST_IDLE) && (i_rd || d_req);
        // D wins only if I is absent or I was granted last time.
        grant_d   = d_req && (!i_rd || lg == OWN_I);
        busy      = (state == ST_READ) || (state == ST_WRITE);
        last_ack  = busy && m_ack && (beat == LAST);
        beat_addr = base + (64'(beat) << 3);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        m_rd     = 1'b0;
        m_wr     = 1'b0;
        m_addr   = '0;
        m_wdata  = '0;
        i_dv     = 1'b0;
        d_dv     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (grant) begin
                    state_nx = (grant_d && d_wr) ? ST_WRITE : ST_READ;
                end
            end
            ST_READ: begin
                m_rd   = 1'b1;
                m_addr = beat_addr;
                if (last_ack) state_nx = ST_DONE;
            end
            ST_WRITE: begin
                m_wr    = 1'b1;
                m_addr  = beat_addr;
                m_wdata = d_wdata[BUS_W*beat +: BUS_W];
                if (last_ack) state_nx = ST_DONE;
            end
            ST_DONE: begin
                i_dv     = (owner == OWN_I);
                d_dv     = (owner == OWN_D);
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            owner    <= OWN_I;
            lg       <= OWN_D;
            beat     <= '0;
            base     <= '0;
            line_buf <= '0;
        end else begin
            if (grant) begin
                owner <= grant_d ? OWN_D : OWN_I;
                lg    <= grant_d ? OWN_D : OWN_I;
                base  <= (grant_d ? d_addr : i_addr) & LINE_MASK;
                beat  <= '0;
            end
            if (busy && m_ack) begin
                if (state == ST_READ) begin
                    line_buf[BUS_W*beat +: BUS_W] <= m_rdata;
                end
                // Stay on the last beat; DONE follows.
                if (beat != LAST) beat <= beat + 1'b1;
            end
        end
    end

    assign i_data  = line_buf;
    assign d_rdata = line_buf;

endmodule

// File: doc/bus_arb.md
BUS_ARB -- requirements
Module: bus_arb

Interface
REQ-001 SHALL have parameter LINE_W, default 1024, meaning cache line width in bits.
REQ-002 SHALL have parameter BUS_W, default 64, meaning memory beat width in bits; BEATS = LINE_W/BUS_W (16).
REQ-003 SHALL have port clk  in  1  single clock, rising edge.
REQ-004 SHALL have port clr_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port i_rd  in  1  instruction-cache line read request, level, held until i_dv.
REQ-006 SHALL have port i_addr  in  64  instruction-cache request byte address.
REQ-007 SHALL have port i_data  out  LINE_W  refill line to instruction cache.
REQ-008 SHALL have port i_dv  out  1  one-cycle pulse; i_data valid.
REQ-009 SHALL have ports d_rd / d_wr  in  1 each  data-cache line read / writeback request, level.
REQ-010 SHALL have ports d_addr  in  64  and d_wdata  in  LINE_W  data-cache address and writeback line.
REQ-011 SHALL have ports d_rdata  out  LINE_W  and d_dv  out  1  data-cache refill line and one-cycle completion pulse, read or write.
REQ-012 SHALL have ports m_rd, m_wr  out  1; m_addr  out  64; m_wdata  out  BUS_W; m_rdata  in  BUS_W; m_ack  in  1 (memory beat done).

Function
REQ-013 SHALL implement FSM states IDLE, READ, WRITE, DONE.
REQ-014 IDLE: SHALL sample requests each cycle; with none pending, SHALL stay in IDLE.
REQ-015 IDLE arbitration: SHALL grant round-robin between I and D using last-grant bit lg; with one requester, SHALL grant it regardless of lg.
REQ-016 On a D grant with d_wr=1, SHALL go to WRITE, even if d_rd=1; otherwise SHALL go to READ.
REQ-017 On grant, SHALL latch owner, base = {addr[63:7], 7'b0}, beat counter = 0, and update lg.
REQ-018 READ/WRITE: SHALL hold m_rd (resp. m_wr) high with m_addr = base + 8*beat.
REQ-019 WRITE: SHALL drive m_wdata = d_wdata[BUS_W*beat +: BUS_W].
REQ-020 Each cycle with m_ack=1: in READ, SHALL store m_rdata into line buffer slot beat; in both states, SHALL increment beat.
REQ-021 Ack on beat BEATS-1: SHALL go to DONE and drop m_rd/m_wr the next cycle; beat SHALL NOT wrap.
REQ-022 DONE: SHALL assert the owner's dv for exactly one cycle, then return to IDLE; no grant occurs in DONE.
REQ-023 Minimum turnaround: SHALL be one IDLE cycle between transactions; read latency = 1 (grant) + 16 acked beats + 1 (DONE).
REQ-024 i_data and d_rdata SHALL both reflect the single line buffer, which SHALL be held until the next READ overwrites it.
REQ-025 Request withdrawal mid-transaction: SHALL be ignored; the transaction SHALL complete and dv SHALL still pulse.
REQ-026 Address or data changes after grant: SHALL be ignored; latched base is used, and d_wdata SHALL be held stable by the requester until d_dv.
REQ-027 m_ack outside READ/WRITE: SHALL be ignored.
REQ-028 Idle outputs: m_rd=m_wr=0 and m_addr=m_wdata=0.

Reset
REQ-029 clr_n=0 SHALL asynchronously force IDLE, beat=0, lg=D (so I wins first tie), line buffer=0, and all outputs to 0, aborting any transaction without dv.

Structure
REQ-030 LINE_W, BUS_W, BEATS and state encodings SHALL live in the shared rv6 package/header.
REQ-031 SHALL be one flat module; no sub-module is needed.

Verification
REQ-032 i_rd=1, i_addr=0x1234, m_ack=1 every cycle -> m_addr 0x1200..0x1278 step 8; i_dv pulses on cycle 18; i_data beat k = m_rdata at beat k.
REQ-033 i_rd and d_rd both asserted from reset -> I served first, then D; raising both again -> I served first (lg alternates).
REQ-034 d_wr=1 and d_rd=1, d_addr=0x80 -> WRITE first; m_wdata beats = d_wdata slices; d_dv pulses once.
REQ-035 m_ack toggling 1/0 -> exactly 16 beats; beat index advances only on ack; DONE after 16th ack.
REQ-036 clr_n low at beat 7 of a READ -> all outputs 0 immediately, no dv; after release with i_rd held -> fresh transaction starts at base.
REQ-037 i_rd dropped at beat 3 -> transaction completes and i_dv still pulses once.
